// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time config sequencer: freezes all cores, writes per-core config registers, drains, then unfreezes.
// Optional build macro BP_CFG_BOOT_TIMEOUT_EN adds an ack-wait timeout (timeout_cycles_p).
module bp_cfg_boot_sequencer #(
  parameter int num_core_p        = 4,
  parameter int core_id_width_p   = 6,
  parameter int cfg_addr_width_p  = 16,
  parameter int cfg_data_width_p  = 32,
  parameter int max_outstanding_p = 4
`ifdef BP_CFG_BOOT_TIMEOUT_EN
  , parameter int timeout_cycles_p = 1024
`endif
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic [cfg_data_width_p-1:0] icache_mode_i,
  input  logic [cfg_data_width_p-1:0] dcache_mode_i,
  input  logic [cfg_data_width_p-1:0] cce_mode_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_id_width_p-1:0]  cfg_dst_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_v_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int out_w_lp = $clog2(max_outstanding_p + 1);
  localparam logic [out_w_lp-1:0] max_out_lp = out_w_lp'(max_outstanding_p);
  localparam logic [core_id_width_p-1:0] last_core_lp = core_id_width_p'(num_core_p - 1);

  localparam logic [cfg_addr_width_p-1:0] addr_freeze_lp  = cfg_addr_width_p'(1);
  localparam logic [cfg_addr_width_p-1:0] addr_core_id_lp = cfg_addr_width_p'(2);
  localparam logic [cfg_addr_width_p-1:0] addr_icache_lp  = cfg_addr_width_p'(3);
  localparam logic [cfg_addr_width_p-1:0] addr_dcache_lp  = cfg_addr_width_p'(4);
  localparam logic [cfg_addr_width_p-1:0] addr_cce_lp     = cfg_addr_width_p'(5);

  typedef enum logic [2:0] {
    IDLE, FREEZE, CONFIG, DRAIN_CFG, UNFREEZE, DRAIN_FIN, DONE
  } state_e;

  state_e                      state_r, state_n;
  logic [core_id_width_p-1:0]  core_r, core_n;
  logic [1:0]                  reg_r, reg_n;
  logic [out_w_lp-1:0]         out_r, out_n;
  logic                        done_r, done_n;
  logic                        err_r, err_n;
  logic                        issue_state, accept, spurious, last_core;

  // Credit count: +1 on accept, -1 on ack, never below zero.
  function automatic logic [out_w_lp-1:0] credit_update(input logic [out_w_lp-1:0] cur,
                                                        input logic inc, input logic dec);
    if (inc && !dec) return cur + out_w_lp'(1);
    if (dec && !inc) return (cur == '0) ? '0 : cur - out_w_lp'(1);
    return cur;
  endfunction

  assign issue_state = (state_r == FREEZE) || (state_r == CONFIG) || (state_r == UNFREEZE);
  assign cfg_v_o     = issue_state && (out_r < max_out_lp);
  assign accept      = cfg_v_o && cfg_ready_i;
  assign spurious    = cfg_ack_v_i && (out_r == '0) && !accept;
  assign last_core   = (core_r == last_core_lp);
  assign busy_o      = (state_r != IDLE) && (state_r != DONE);
  assign done_o      = done_r;
  assign err_o       = err_r;

  always_comb begin
    cfg_dst_o  = '0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    if (cfg_v_o) begin
      cfg_dst_o = core_r;
      unique case (state_r)
        FREEZE: begin
          cfg_addr_o = addr_freeze_lp;
          cfg_data_o = cfg_data_width_p'(1);
        end
        UNFREEZE: cfg_addr_o = addr_freeze_lp;
        CONFIG: begin
          unique case (reg_r)
            2'd0: begin
              cfg_addr_o = addr_core_id_lp;
              cfg_data_o = cfg_data_width_p'(core_r);
            end
            2'd1: begin
              cfg_addr_o = addr_icache_lp;
              cfg_data_o = icache_mode_i;
            end
            2'd2: begin
              cfg_addr_o = addr_dcache_lp;
              cfg_data_o = dcache_mode_i;
            end
            default: begin
              cfg_addr_o = addr_cce_lp;
              cfg_data_o = cce_mode_i;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef BP_CFG_BOOT_TIMEOUT_EN
  localparam int tmo_w_lp = $clog2(timeout_cycles_p + 1);
  logic [tmo_w_lp-1:0] tmo_r, tmo_n;
  logic                tmo_hit;

  // Counts idle cycles spent waiting on acks; any channel activity restarts it.
  always_comb begin
    tmo_n   = tmo_r;
    tmo_hit = 1'b0;
    if (accept || cfg_ack_v_i) begin
      tmo_n = '0;
    end else if (out_r != '0) begin
      if (tmo_r == tmo_w_lp'(timeout_cycles_p - 1)) begin
        tmo_hit = 1'b1;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo_r + tmo_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) tmo_r <= '0;
    else            tmo_r <= tmo_n;
  end
`endif

  always_comb begin
    state_n = state_r;
    core_n  = core_r;
    reg_n   = reg_r;
    out_n   = credit_update(out_r, accept, cfg_ack_v_i);
    done_n  = done_r;
    err_n   = err_r;
    unique case (state_r)
      IDLE, DONE: begin
        if (start_i) begin
          state_n = FREEZE;
          core_n  = '0;
          reg_n   = '0;
          done_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      FREEZE, UNFREEZE: begin
        if (accept) begin
          if (last_core) begin
            state_n = (state_r == FREEZE) ? CONFIG : DRAIN_FIN;
            core_n  = '0;
          end else begin
            core_n = core_r + core_id_width_p'(1);
          end
        end
      end
      CONFIG: begin
        if (accept) begin
          reg_n = reg_r + 2'd1;
          if (reg_r == 2'd3) begin
            if (last_core) begin
              state_n = DRAIN_CFG;
              core_n  = '0;
            end else begin
              core_n = core_r + core_id_width_p'(1);
            end
          end
        end
      end
      // Barrier: nothing is unfrozen until every config write has been acked.
      DRAIN_CFG: if (out_r == '0) state_n = UNFREEZE;
      DRAIN_FIN: begin
        if (out_r == '0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (spurious) err_n = 1'b1;
`ifdef BP_CFG_BOOT_TIMEOUT_EN
    if (tmo_hit) begin
      state_n = DONE;
      done_n  = 1'b0;
      err_n   = 1'b1;
      out_n   = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      core_r  <= '0;
      reg_r   <= '0;
      out_r   <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      core_r  <= core_n;
      reg_r   <= reg_n;
      out_r   <= out_n;
      done_r  <= done_n;
      err_r   <= err_n;
    end
  end

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Randomized bench for bp_cfg_boot_sequencer: fabric model with random ready/ack delays against an ordered write list.
`timescale 1ns/1ps
module tb_bp_cfg_boot_sequencer;

  localparam int N    = 4;
  localparam int MAXO = 2;
`ifdef BP_CFG_BOOT_TIMEOUT_EN
  localparam int LONG_DLY = 12;
`else
  localparam int LONG_DLY = 50;
`endif

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [31:0] icache_mode_i, dcache_mode_i, cce_mode_i;
  logic        cfg_v_o, cfg_ready_i, cfg_ack_v_i;
  logic [5:0]  cfg_dst_o;
  logic [15:0] cfg_addr_o;
  logic [31:0] cfg_data_o;
  logic        busy_o, done_o, err_o;

  always #5 clk = ~clk;

  bp_cfg_boot_sequencer #(
    .num_core_p(N), .core_id_width_p(6), .cfg_addr_width_p(16),
    .cfg_data_width_p(32), .max_outstanding_p(MAXO)
`ifdef BP_CFG_BOOT_TIMEOUT_EN
    , .timeout_cycles_p(16)
`endif
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .icache_mode_i(icache_mode_i), .dcache_mode_i(dcache_mode_i), .cce_mode_i(cce_mode_i),
    .cfg_v_o(cfg_v_o), .cfg_ready_i(cfg_ready_i), .cfg_dst_o(cfg_dst_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ack_v_i(cfg_ack_v_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [5:0]  dst;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  wr_t  exp_q[$];
  int   ack_q[$];
  int   nw, acks, model_out;
  int   ready_pct, ack_min, ack_max, long_idx, release_n;
  bit   hold_acks, prev_stall, seen_unfreeze;
  logic [53:0] prev_bus;
  int   lat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic wr_t mk(input int c, input int a, input logic [31:0] d);
    wr_t w;
    w.dst  = 6'(c);
    w.addr = 16'(a);
    w.data = d;
    return w;
  endfunction

  // Expected write stream: freeze all, 4 config regs per core, unfreeze all.
  function automatic void build_exp();
    exp_q.delete();
    for (int c = 0; c < N; c++) exp_q.push_back(mk(c, 1, 32'd1));
    for (int c = 0; c < N; c++) begin
      exp_q.push_back(mk(c, 2, 32'(c)));
      exp_q.push_back(mk(c, 3, icache_mode_i));
      exp_q.push_back(mk(c, 4, dcache_mode_i));
      exp_q.push_back(mk(c, 5, cce_mode_i));
    end
    for (int c = 0; c < N; c++) exp_q.push_back(mk(c, 1, 32'd0));
  endfunction

  // One fabric cycle: drive ready/ack at negedge, observe 1ns later.
  task automatic tick();
    bit  ack_now;
    wr_t obs;
    @(negedge clk);
    cyc++;
    start_i     = 1'b0;
    cfg_ready_i = ($urandom_range(99) < ready_pct);
    ack_now     = 1'b0;
    if (ack_q.size() != 0 && ack_q[0] <= cyc && (!hold_acks || release_n > 0)) begin
      ack_now = 1'b1;
      void'(ack_q.pop_front());
      if (hold_acks) release_n--;
    end
    cfg_ack_v_i = ack_now;
    #1;
    if (prev_stall)
      check("hold_stable", 64'({cfg_v_o, cfg_dst_o, cfg_addr_o, cfg_data_o}), 64'({1'b1, prev_bus}));
    if (model_out >= MAXO) check("credit_limit", 64'(cfg_v_o), 64'(0));
    if (cfg_v_o && cfg_ready_i) begin
      obs = '{dst: cfg_dst_o, addr: cfg_addr_o, data: cfg_data_o};
      if (nw < exp_q.size()) check($sformatf("write%0d", nw), 64'(obs), 64'(exp_q[nw]));
      else check("extra_write", 64'(nw), 64'(exp_q.size()));
      if (obs.addr == 16'd1 && obs.data == 32'd0 && !seen_unfreeze) begin
        seen_unfreeze = 1'b1;
        check("barrier_acks", 64'(acks), 64'(5 * N));
      end
      ack_q.push_back(cyc + ((nw == long_idx) ? LONG_DLY : int'($urandom_range(ack_max, ack_min))));
      nw++;
      model_out++;
    end
    if (ack_now) begin
      model_out--;
      acks++;
    end
    prev_stall = cfg_v_o && !cfg_ready_i;
    prev_bus   = {cfg_dst_o, cfg_addr_o, cfg_data_o};
  endtask

  task automatic begin_seq();
    icache_mode_i = $urandom;
    dcache_mode_i = $urandom;
    cce_mode_i    = $urandom;
    build_exp();
    nw = 0; acks = 0; prev_stall = 1'b0; seen_unfreeze = 1'b0;
    @(negedge clk);
    cyc++;
    start_i = 1'b1; cfg_ready_i = 1'b0; cfg_ack_v_i = 1'b0;
    @(posedge clk);
    #1;
    check("start_busy", 64'(busy_o), 64'(1));
    check("start_done", 64'(done_o), 64'(0));
    check("start_err",  64'(err_o),  64'(0));
  endtask

  task automatic finish_seq(input int budget, output int n);
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    check("seq_done",   64'(done_o), 64'(1));
    check("seq_busy",   64'(busy_o), 64'(0));
    check("seq_err",    64'(err_o),  64'(0));
    check("seq_writes", 64'(nw),     64'(6 * N));
    check("seq_outstanding", 64'(model_out), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_v"},    64'(cfg_v_o),    64'(0));
    check({tag, "_bus"},  64'({cfg_dst_o, cfg_addr_o, cfg_data_o}), 64'(0));
    check({tag, "_busy"}, 64'(busy_o),     64'(0));
    check({tag, "_done"}, 64'(done_o),     64'(0));
    check({tag, "_err"},  64'(err_o),      64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i = 1'b0; start_i = 1'b0; cfg_ready_i = 1'b0; cfg_ack_v_i = 1'b0;
    icache_mode_i = '0; dcache_mode_i = '0; cce_mode_i = '0;
    nw = 0; acks = 0; model_out = 0; hold_acks = 1'b0; release_n = 0;
    ready_pct = 100; ack_min = 1; ack_max = 1; long_idx = -1;
    prev_stall = 1'b0; seen_unfreeze = 1'b0; prev_bus = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n_i = 1'b1;

    // Always-ready fabric, 1-cycle acks.
    begin_seq();
    finish_seq(200, lat);
    check("latency_min", 64'(lat + 1 >= 6 * N + 3), 64'(1));

    // Withheld acks: credit limit, then one release lets exactly one more write through.
    begin_seq();
    hold_acks = 1'b1; release_n = 0;
    repeat (6) tick();
    check("credit_accepts", 64'(nw), 64'(MAXO));
    check("credit_v_low",   64'(cfg_v_o), 64'(0));
    release_n = 1;
    tick();
    check("credit_release_cycle", 64'(nw), 64'(MAXO));
    tick();
    check("credit_one_more", 64'(nw), 64'(MAXO + 1));
    tick();
    check("credit_no_extra", 64'(nw), 64'(MAXO + 1));
    hold_acks = 1'b0;
    finish_seq(200, lat);

    // Random backpressure and ack latency.
    ready_pct = 60; ack_min = 1; ack_max = 4;
    repeat (3) begin
      begin_seq();
      finish_seq(500, lat);
    end

    // Last config ack held back: no unfreeze until it lands.
    ready_pct = 100; ack_min = 1; ack_max = 1; long_idx = 5 * N - 1;
    begin_seq();
    finish_seq(300, lat);
    check("long_latency", 64'(lat >= 5 * N + LONG_DLY), 64'(1));
    long_idx = -1;

    // Reset mid-CONFIG.
    ack_max = 2;
    begin_seq();
    for (int k = 0; k < 100 && nw < N + 4; k++) tick();
    #2;
    reset_n_i = 1'b0; cfg_ready_i = 1'b0; cfg_ack_v_i = 1'b0;
    #1;
    check_all_zero("midreset");
    ack_q.delete(); model_out = 0; prev_stall = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;

    // Spurious ack in IDLE, then a clean sequence clears the error.
    @(negedge clk);
    cfg_ack_v_i = 1'b1;
    @(negedge clk);
    cfg_ack_v_i = 1'b0;
    #1;
    check("spurious_err",  64'(err_o),  64'(1));
    check("spurious_busy", 64'(busy_o), 64'(0));
    begin_seq();
    finish_seq(300, lat);

`ifdef BP_CFG_BOOT_TIMEOUT_EN
    // Acks never return: timeout ends the sequence with an error.
    ack_max = 1;
    begin_seq();
    hold_acks = 1'b1; release_n = 0;
    repeat (8) tick();
    check("tmo_still_busy", 64'(busy_o), 64'(1));
    repeat (30) tick();
    check("tmo_err",  64'(err_o),  64'(1));
    check("tmo_done", 64'(done_o), 64'(0));
    check("tmo_busy", 64'(busy_o), 64'(0));
    check("tmo_v",    64'(cfg_v_o), 64'(0));
    hold_acks = 1'b0; ack_q.delete(); model_out = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
